next_line_prefetcher: RTL and testbench

Sequential next-line prefetcher and memory arbiter sitting between the prefetch-capable cache controller and the cacheline adapter. When the controller reports a demand read miss, the block records the miss address and waits for the demand fill. It then fetches line+1 from physical memory into a one-line buffer and offers it to the controller for installation through the `prefetch_ready` handshake. Demand traffic always has priority for the shared adapter.

---
 rtl/next_line_prefetcher.sv | 175 +++++++++++++++++
 tb/tb_next_line_prefetcher.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/next_line_prefetcher.sv
// next_line_prefetcher
//
// Sequential next-line prefetcher plus arbiter for the shared cacheline
// adapter. When the controller reports a demand read miss, the block records
// line+1. After the demand fill returns, it checks whether that line is
// already cached. If it is not, the block fetches the line into a one-line
// buffer and offers it to the controller through prefetch_ready. Demand
// traffic always has priority at the adapter.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   prefetch_start/miss_addr controller demand-read miss notification
//   pf_consume               controller installs the buffered line this cycle
//   pf_hit/pf_lru/pf_victim_dirty
//                            datapath lookup results for pf_addr
//   prefetch_ready           buffered line may be installed
//   pf_cache_way             way to fill (follows pf_lru)
//   pf_addr/pf_line          line-aligned prefetch address and buffered data
//   cache_pmem_*             controller demand port (resp routed back)
//   adapter_*                cacheline adapter port

module next_line_prefetcher #(
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 5,
    parameter int LINE_W   = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prefetch_start,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic              pf_consume,
    input  logic              pf_hit,
    input  logic              pf_lru,
    input  logic              pf_victim_dirty,
    output logic              prefetch_ready,
    output logic              pf_cache_way,
    output logic [ADDR_W-1:0] pf_addr,
    output logic [LINE_W-1:0] pf_line,
    input  logic              cache_pmem_read,
    input  logic              cache_pmem_write,
    input  logic [ADDR_W-1:0] cache_pmem_address,
    output logic              cache_pmem_resp,
    output logic              adapter_read,
    output logic              adapter_write,
    output logic [ADDR_W-1:0] adapter_address,
    input  logic              adapter_resp,
    input  logic [LINE_W-1:0] adapter_rdata
);

    localparam int LINE_AW = ADDR_W - OFFSET_W;

    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_LOOKUP, S_FETCH, S_READY
    } pf_state_t;

    typedef enum logic [1:0] {
        OWN_NONE, OWN_DEMAND, OWN_PF
    } owner_t;

    pf_state_t          state;
    owner_t             owner;
    logic               drop_pending;

    logic               demand_req;
    logic               pf_req;
    logic               route_demand;
    logic               route_pf;
    logic               demand_grant;
    logic               pf_done;
    logic               demand_done;
    logic               wr_hits_pf;
    logic [LINE_AW:0]   next_line;

    assign demand_req   = cache_pmem_read | cache_pmem_write;
    assign pf_req       = (state == S_FETCH);

    // Requests are routed combinationally in the cycle the owner is still
    // NONE. The adapter therefore sees the request in the same cycle that
    // the grant is registered.
    assign route_demand = (owner == OWN_DEMAND) | ((owner == OWN_NONE) & demand_req);
    assign route_pf     = (owner == OWN_PF) | ((owner == OWN_NONE) & ~demand_req & pf_req);
    assign demand_grant = (owner == OWN_NONE) & demand_req;
    assign pf_done      = (owner == OWN_PF) & adapter_resp;
    assign demand_done  = (owner == OWN_DEMAND) & adapter_resp;

    // A demand write to the buffered line makes the buffer stale.
    assign wr_hits_pf   = demand_grant & cache_pmem_write &
                          (cache_pmem_address[ADDR_W-1:OFFSET_W] == pf_addr[ADDR_W-1:OFFSET_W]);

    // The extra MSB is the carry-out. It flags a wrap past the last line.
    assign next_line    = {1'b0, miss_addr[ADDR_W-1:OFFSET_W]} + 1'b1;

    assign cache_pmem_resp = demand_done;
    assign pf_cache_way    = pf_lru;
    assign prefetch_ready  = (state == S_READY) & ~pf_hit & ~pf_victim_dirty;

    always_comb begin
        adapter_read    = 1'b0;
        adapter_write   = 1'b0;
        adapter_address = '0;
        if (route_demand) begin
            adapter_read    = cache_pmem_read;
            adapter_write   = cache_pmem_write;
            adapter_address = cache_pmem_address;
        end else if (route_pf) begin
            adapter_read    = 1'b1;
            adapter_address = pf_addr;
        end
    end

    // Arbiter owner: held from grant until the adapter response.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner <= OWN_NONE;
        end else begin
            case (owner)
                OWN_NONE: begin
                    if (demand_req)  owner <= OWN_DEMAND;
                    else if (pf_req) owner <= OWN_PF;
                end
                OWN_DEMAND, OWN_PF: begin
                    if (adapter_resp) owner <= OWN_NONE;
                end
                default: owner <= OWN_NONE;
            endcase
        end
    end

    // Prefetch sequencer
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            drop_pending <= 1'b0;
            pf_addr      <= '0;
            pf_line      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    drop_pending <= 1'b0;
                    if (prefetch_start && !next_line[LINE_AW]) begin
                        pf_addr <= {next_line[LINE_AW-1:0], {OFFSET_W{1'b0}}};
                        state   <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (demand_done && cache_pmem_read) state <= S_LOOKUP;
                end
                S_LOOKUP: begin
                    state <= pf_hit ? S_IDLE : S_FETCH;
                end
                S_FETCH: begin
                    // The PF transfer already in flight must still complete.
                    // A stale line is discarded when its response arrives.
                    if (wr_hits_pf) drop_pending <= 1'b1;
                    if (pf_done) begin
                        if (drop_pending || wr_hits_pf) begin
                            state <= S_IDLE;
                        end else begin
                            pf_line <= adapter_rdata;
                            state   <= S_READY;
                        end
                    end
                end
                S_READY: begin
                    // A dirty victim cannot be written back during a
                    // prefetch install, so the line is dropped instead.
                    if (pf_hit || pf_victim_dirty || pf_consume || wr_hits_pf)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_next_line_prefetcher.sv
module tb_next_line_prefetcher;

    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 5;
    localparam int LINE_W   = 256;
    localparam int LAT      = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              prefetch_start = 1'b0;
    logic [ADDR_W-1:0] miss_addr = '0;
    logic              pf_consume = 1'b0;
    logic              pf_hit = 1'b0;
    logic              pf_lru = 1'b0;
    logic              pf_victim_dirty = 1'b0;
    logic              prefetch_ready;
    logic              pf_cache_way;
    logic [ADDR_W-1:0] pf_addr;
    logic [LINE_W-1:0] pf_line;
    logic              cache_pmem_read = 1'b0;
    logic              cache_pmem_write = 1'b0;
    logic [ADDR_W-1:0] cache_pmem_address = '0;
    logic              cache_pmem_resp;
    logic              adapter_read;
    logic              adapter_write;
    logic [ADDR_W-1:0] adapter_address;
    logic              adapter_resp = 1'b0;
    logic [LINE_W-1:0] adapter_rdata = '0;

    int n_checks = 0;
    int n_errors = 0;

    logic [ADDR_W-1:0] addr_log[$];
    logic              mem_busy = 1'b0;
    int                mem_cnt = 0;
    logic [ADDR_W-1:0] mem_addr = '0;

    next_line_prefetcher #(
        .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .LINE_W(LINE_W)
    ) dut (
        .clk(clk), .rst(rst),
        .prefetch_start(prefetch_start), .miss_addr(miss_addr),
        .pf_consume(pf_consume), .pf_hit(pf_hit), .pf_lru(pf_lru),
        .pf_victim_dirty(pf_victim_dirty),
        .prefetch_ready(prefetch_ready), .pf_cache_way(pf_cache_way),
        .pf_addr(pf_addr), .pf_line(pf_line),
        .cache_pmem_read(cache_pmem_read), .cache_pmem_write(cache_pmem_write),
        .cache_pmem_address(cache_pmem_address), .cache_pmem_resp(cache_pmem_resp),
        .adapter_read(adapter_read), .adapter_write(adapter_write),
        .adapter_address(adapter_address), .adapter_resp(adapter_resp),
        .adapter_rdata(adapter_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [LINE_W-1:0] line_of(input logic [ADDR_W-1:0] a);
        return {4{a, ~a}};
    endfunction

    task automatic check(input string tag, input logic [LINE_W-1:0] got,
                         input logic [LINE_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Adapter model: fixed latency, one-cycle response, abandons on reset.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                adapter_resp = 1'b0;
                mem_busy     = 1'b0;
            end else begin
                adapter_resp = 1'b0;
                if (mem_busy) begin
                    mem_cnt--;
                    if (mem_cnt == 0) begin
                        adapter_resp  = 1'b1;
                        adapter_rdata = line_of(mem_addr);
                        mem_busy      = 1'b0;
                    end
                end else if (adapter_read || adapter_write) begin
                    mem_busy = 1'b1;
                    mem_cnt  = LAT;
                    mem_addr = adapter_address;
                    addr_log.push_back(adapter_address);
                end
            end
        end
    end

    task automatic wait_resp(input string tag);
        bit done = 0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            #3;
            if (cache_pmem_resp) done = 1;
        end
        check(tag, done, 1'b1);
        @(negedge clk);
        cache_pmem_read  = 1'b0;
        cache_pmem_write = 1'b0;
        prefetch_start   = 1'b0;
    endtask

    task automatic demand_xfer(input string tag, input logic wr,
                               input logic [ADDR_W-1:0] addr, input logic start);
        cache_pmem_read    = ~wr;
        cache_pmem_write   = wr;
        cache_pmem_address = addr;
        miss_addr          = addr;
        prefetch_start     = start;
        wait_resp(tag);
    endtask

    task automatic wait_pf_resp(input string tag, input logic [ADDR_W-1:0] exp_addr);
        bit done = 0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            #3;
            if (adapter_resp) done = 1;
        end
        check({tag, "_seen"}, done, 1'b1);
        check({tag, "_no_cresp"}, cache_pmem_resp, 1'b0);
        check({tag, "_addr"}, adapter_address, exp_addr);
    endtask

    initial begin
        int nb;
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        repeat (3) @(negedge clk);
        #3;
        check("rst_ready", prefetch_ready, 1'b0);
        check("rst_pf_addr", pf_addr, '0);
        check("rst_pf_line", pf_line, '0);
        check("rst_aread", adapter_read, 1'b0);
        check("rst_awrite", adapter_write, 1'b0);
        check("rst_aaddr", adapter_address, '0);
        check("rst_cresp", cache_pmem_resp, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Basic miss: demand 0x1040 then prefetch 0x1060
        pf_lru = 1'b1;
        demand_xfer("t1_demand", 1'b0, 32'h0000_1040, 1'b1);
        check("t1_log0", addr_log[0], 32'h0000_1040);
        @(negedge clk);
        #3;
        check("t1_pf_read_rise", adapter_read, 1'b1);
        check("t1_pf_addr_rise", adapter_address, 32'h0000_1060);
        wait_pf_resp("t1_pf", 32'h0000_1060);
        @(negedge clk);
        #3;
        check("t1_ready", prefetch_ready, 1'b1);
        check("t1_line", pf_line, line_of(32'h0000_1060));
        check("t1_pf_addr", pf_addr, 32'h0000_1060);
        check("t1_way", pf_cache_way, 1'b1);
        check("t1_log1", addr_log[1], 32'h0000_1060);
        @(negedge clk);
        pf_consume = 1'b1;
        @(negedge clk);
        pf_consume = 1'b0;
        #3;
        check("t1_consumed", prefetch_ready, 1'b0);

        // Prefetch target already cached
        @(negedge clk);
        pf_hit = 1'b1;
        nb = addr_log.size();
        demand_xfer("t2_demand", 1'b0, 32'h0000_2000, 1'b1);
        repeat (6) @(negedge clk);
        #3;
        check("t2_no_pf", addr_log.size(), nb + 1);
        check("t2_aread", adapter_read, 1'b0);
        check("t2_pf_addr", pf_addr, 32'h0000_2020);
        @(negedge clk);
        pf_hit = 1'b0;

        // Demand arriving one cycle after the PF read starts
        demand_xfer("t3_demand", 1'b0, 32'h0000_3000, 1'b1);
        @(negedge clk);
        #3;
        check("t3_pf_start", adapter_address, 32'h0000_3020);
        @(negedge clk);
        cache_pmem_read    = 1'b1;
        cache_pmem_address = 32'h0000_4000;
        miss_addr          = 32'h0000_4000;
        prefetch_start     = 1'b1;
        wait_pf_resp("t3_pf", 32'h0000_3020);
        @(negedge clk);
        #3;
        check("t3_grant_read", adapter_read, 1'b1);
        check("t3_grant_addr", adapter_address, 32'h0000_4000);
        wait_resp("t3_demand2");
        #3;
        check("t3_ready", prefetch_ready, 1'b1);
        check("t3_line", pf_line, line_of(32'h0000_3020));
        @(negedge clk);
        pf_consume = 1'b1;
        @(negedge clk);
        pf_consume = 1'b0;

        // Dirty victim: line dropped
        demand_xfer("t4_demand", 1'b0, 32'h0000_5000, 1'b1);
        pf_victim_dirty = 1'b1;
        wait_pf_resp("t4_pf", 32'h0000_5020);
        @(negedge clk);
        #3;
        check("t4_ready_dirty", prefetch_ready, 1'b0);
        @(negedge clk);
        pf_victim_dirty = 1'b0;
        #3;
        check("t4_back_idle", prefetch_ready, 1'b0);

        // Demand writeback to the buffered line
        @(negedge clk);
        demand_xfer("t5_demand", 1'b0, 32'h0000_1040, 1'b1);
        wait_pf_resp("t5_pf", 32'h0000_1060);
        @(negedge clk);
        #3;
        check("t5_ready", prefetch_ready, 1'b1);
        @(negedge clk);
        cache_pmem_write   = 1'b1;
        cache_pmem_address = 32'h0000_1060;
        @(negedge clk);
        #3;
        check("t5_wb_drop", prefetch_ready, 1'b0);
        wait_resp("t5_wb");

        // Miss to the last line: no prefetch
        nb = addr_log.size();
        demand_xfer("t6_demand", 1'b0, 32'hFFFF_FFE0, 1'b1);
        repeat (6) @(negedge clk);
        #3;
        check("t6_no_pf", addr_log.size(), nb + 1);
        check("t6_aread", adapter_read, 1'b0);
        check("t6_pf_addr", pf_addr, 32'h0000_1060);

        // Reset in the middle of a PF transfer
        @(negedge clk);
        demand_xfer("t7_demand", 1'b0, 32'h0000_6000, 1'b1);
        @(negedge clk);
        #3;
        check("t7_pf_busy", adapter_read, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #3;
        check("t7_ready", prefetch_ready, 1'b0);
        check("t7_pf_addr", pf_addr, '0);
        check("t7_pf_line", pf_line, '0);
        check("t7_aread", adapter_read, 1'b0);
        check("t7_awrite", adapter_write, 1'b0);
        check("t7_aaddr", adapter_address, '0);
        check("t7_cresp", cache_pmem_resp, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        demand_xfer("t7_after", 1'b0, 32'h0000_7000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
